// File: rtl/operand_fetch_if.sv
// Operand-fetch stage signal bundle: decode request, regfile ports, writeback and execute bundle.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface operand_fetch_if #(
    parameter int unsigned DATAPATH_WIDTH     = 64,
    parameter int unsigned REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH         = 8
);
    logic                          id_valid;
    logic                          id_ready;
    logic [REGFILE_ADDR_WIDTH-1:0] id_rs1;
    logic [REGFILE_ADDR_WIDTH-1:0] id_rs2;
    logic                          id_use_rs1;
    logic                          id_use_rs2;
    logic [REGFILE_ADDR_WIDTH-1:0] id_rd;
    logic                          id_rd_wen;
    logic [CTRL_WIDTH-1:0]         id_ctrl;

    logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_out;
    logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_out;
    logic [DATAPATH_WIDTH-1:0]     R1_data_in;
    logic [DATAPATH_WIDTH-1:0]     R2_data_in;

    logic                          wb_valid;
    logic [REGFILE_ADDR_WIDTH-1:0] wb_addr;
    logic [DATAPATH_WIDTH-1:0]     wb_data;
    logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out;
    logic [DATAPATH_WIDTH-1:0]     WR_data_out;
    logic                          wena_out;

    logic                          ex_valid;
    logic                          ex_ready;
    logic [DATAPATH_WIDTH-1:0]     ex_op_a;
    logic [DATAPATH_WIDTH-1:0]     ex_op_b;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_rd;
    logic                          ex_rd_wen;
    logic [CTRL_WIDTH-1:0]         ex_ctrl;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wen, id_ctrl,
        input  R1_data_in, R2_data_in, wb_valid, wb_addr, wb_data, ex_ready,
        output id_ready, R1_addr_out, R2_addr_out, WR_addr_out, WR_data_out, wena_out,
        output ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen, ex_ctrl
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wen, id_ctrl,
        output R1_data_in, R2_data_in, wb_valid, wb_addr, wb_data, ex_ready,
        input  id_ready, R1_addr_out, R2_addr_out, WR_addr_out, WR_data_out, wena_out,
        input  ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen, ex_ctrl
    );
endinterface

// File: rtl/operand_fetch.sv
// Register-read/issue stage: regfile read with writeback bypass, scoreboard RAW/WAW stall,
// and a single registered operand bundle towards execute.
module operand_fetch #(
    parameter int unsigned DATAPATH_WIDTH     = 64,
    parameter int unsigned REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH         = 8
) (
    input logic            clk,
    input logic            reset,
    operand_fetch_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REGFILE_ADDR_WIDTH;

    logic [NumRegs-1:0]            pending_q, pending_d;
    logic                          ex_valid_q, ex_valid_d;
    logic [DATAPATH_WIDTH-1:0]     ex_op_a_q, ex_op_b_q;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_rd_q;
    logic                          ex_rd_wen_q;
    logic [CTRL_WIDTH-1:0]         ex_ctrl_q;

    logic                          wb_hit1, wb_hit2, wb_hit_rd;
    logic                          unres1, unres2, waw, hazard, issue;
    logic [DATAPATH_WIDTH-1:0]     op_a, op_b;

    // Regfile ports are pure passthroughs and stay live during reset.
    assign bus.R1_addr_out = bus.id_rs1;
    assign bus.R2_addr_out = bus.id_rs2;
    assign bus.WR_addr_out = bus.wb_addr;
    assign bus.WR_data_out = bus.wb_data;
    assign bus.wena_out    = bus.wb_valid;

    // The regfile write lands on the same edge as issue, so forward it here.
    assign wb_hit1   = bus.wb_valid && (bus.wb_addr == bus.id_rs1);
    assign wb_hit2   = bus.wb_valid && (bus.wb_addr == bus.id_rs2);
    assign wb_hit_rd = bus.wb_valid && (bus.wb_addr == bus.id_rd);
    assign op_a      = wb_hit1 ? bus.wb_data : bus.R1_data_in;
    assign op_b      = wb_hit2 ? bus.wb_data : bus.R2_data_in;

    assign unres1 = bus.id_use_rs1 && pending_q[bus.id_rs1] && !wb_hit1;
    assign unres2 = bus.id_use_rs2 && pending_q[bus.id_rs2] && !wb_hit2;
    assign waw    = bus.id_rd_wen && pending_q[bus.id_rd] && !wb_hit_rd;
    assign hazard = unres1 || unres2 || waw;

    assign bus.id_ready = (!ex_valid_q || bus.ex_ready) && !hazard && reset;
    assign issue        = bus.id_valid && bus.id_ready;

    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid) pending_d[bus.wb_addr] = 1'b0;
        // Applied after the clear so a same-address set wins.
        if (issue && bus.id_rd_wen) pending_d[bus.id_rd] = 1'b1;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (issue) begin
            ex_valid_d = 1'b1;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q   <= '0;
            ex_valid_q  <= 1'b0;
            ex_op_a_q   <= '0;
            ex_op_b_q   <= '0;
            ex_rd_q     <= '0;
            ex_rd_wen_q <= 1'b0;
            ex_ctrl_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            if (issue) begin
                ex_op_a_q   <= op_a;
                ex_op_b_q   <= op_b;
                ex_rd_q     <= bus.id_rd;
                ex_rd_wen_q <= bus.id_rd_wen;
                ex_ctrl_q   <= bus.id_ctrl;
            end
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_op_a   = ex_op_a_q;
    assign bus.ex_op_b   = ex_op_b_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_rd_wen = ex_rd_wen_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small behavioural register file model.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic reset;
    logic load_rf;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] rf [32];

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf_init(int i);
        if (i == 3) return 64'h11;
        if (i == 4) return 64'h22;
        return 64'h1000 + 64'(i);
    endfunction

    always @(posedge clk) begin
        if (load_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (bus.wena_out) begin
            rf[bus.WR_addr_out] <= bus.WR_data_out;
        end
    end

    assign bus.R1_data_in = rf[bus.R1_addr_out];
    assign bus.R2_data_in = rf[bus.R2_addr_out];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wen, input logic [7:0] ctrl);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_use_rs1 = u1; bus.id_rs2 = rs2;
        bus.id_use_rs2 = u2; bus.id_rd = rd; bus.id_rd_wen = wen; bus.id_ctrl = ctrl;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b0; load_rf = 1'b1; bus.ex_ready = 1'b1;
        wb(1'b0, 5'd0, 64'd0);
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 8'hAA);
        tick(); tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b want 0", bus.id_ready); end
        checks++; if (bus.ex_op_a !== 64'd0 || bus.ex_op_b !== 64'd0) begin errors++; $display("FAIL reset_ops: got %h %h want 0 0", bus.ex_op_a, bus.ex_op_b); end
        checks++; if ({bus.ex_rd, bus.ex_rd_wen, bus.ex_ctrl} !== 14'd0) begin errors++; $display("FAIL reset_rd_ctrl: got %h %b %h want 0", bus.ex_rd, bus.ex_rd_wen, bus.ex_ctrl); end
        checks++; if (bus.R1_addr_out !== 5'd3 || bus.R2_addr_out !== 5'd4) begin errors++; $display("FAIL reset_passthrough: got %0d %0d want 3 4", bus.R1_addr_out, bus.R2_addr_out); end
        reset = 1'b1; load_rf = 1'b0; bus.id_valid = 1'b0;
        tick();
    endtask

    task automatic test_independent();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 8'h5A);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL indep_valid: got %b want 1", bus.ex_valid); end
        checks++; if (bus.ex_op_a !== 64'h11 || bus.ex_op_b !== 64'h22) begin errors++; $display("FAIL indep_ops: got %h %h want 11 22", bus.ex_op_a, bus.ex_op_b); end
        checks++; if (bus.ex_rd !== 5'd5 || bus.ex_rd_wen !== 1'b1 || bus.ex_ctrl !== 8'h5A) begin errors++; $display("FAIL indep_rd_ctrl: got %0d %b %h want 5 1 5a", bus.ex_rd, bus.ex_rd_wen, bus.ex_ctrl); end
    endtask

    task automatic test_raw_bypass();
        drive(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 8'h01);
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0: got %b want 0", bus.id_ready); end
        tick();
        checks++; if (bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b0) begin errors++; $display("FAIL raw_stall1: got ready %b valid %b want 0 0", bus.id_ready, bus.ex_valid); end
        wb(1'b1, 5'd5, 64'hDEAD);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", bus.id_ready); end
        checks++; if (bus.wena_out !== 1'b1 || bus.WR_addr_out !== 5'd5 || bus.WR_data_out !== 64'hDEAD) begin errors++; $display("FAIL wr_passthrough: got %b %0d %h want 1 5 dead", bus.wena_out, bus.WR_addr_out, bus.WR_data_out); end
        tick();
        wb(1'b0, 5'd0, 64'd0);
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 64'hDEAD || bus.ex_op_b !== 64'h22) begin errors++; $display("FAIL raw_bypass: got %b %h %h want 1 dead 22", bus.ex_valid, bus.ex_op_a, bus.ex_op_b); end
        checks++; if (bus.ex_rd !== 5'd6) begin errors++; $display("FAIL raw_rd: got %0d want 6", bus.ex_rd); end
        // r5 cleared; read it on both sources from the regfile now holding DEAD
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 8'h02);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL raw_cleared: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_op_a !== 64'hDEAD || bus.ex_op_b !== 64'hDEAD) begin errors++; $display("FAIL same_src: got %h %h want dead dead", bus.ex_op_a, bus.ex_op_b); end
        tick();
    endtask

    task automatic test_waw();
        drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 8'h10);
        tick();
        drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 8'h11);
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL waw_stall0: got %b want 0", bus.id_ready); end
        tick();
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL waw_stall1: got %b want 0", bus.id_ready); end
        wb(1'b1, 5'd7, 64'h77);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL waw_release: got %b want 1", bus.id_ready); end
        tick();
        wb(1'b0, 5'd0, 64'd0);
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'h11) begin errors++; $display("FAIL waw_issue: got %b %h want 1 11", bus.ex_valid, bus.ex_ctrl); end
        // set wins: r7 must still be pending
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 8'h12);
        #1;
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL waw_set_wins: got %b want 0", bus.id_ready); end
        tick();
        wb(1'b1, 5'd7, 64'h777);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_op_a !== 64'h777 || bus.ex_ctrl !== 8'h12) begin errors++; $display("FAIL waw_followup: got %h %h want 777 12", bus.ex_op_a, bus.ex_ctrl); end
    endtask

    task automatic test_unused_source();
        // r6 still pending but not used
        drive(1'b1, 5'd6, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 8'h20);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL unused_ready: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_op_a !== 64'h1006 || bus.ex_op_b !== 64'h11) begin errors++; $display("FAIL unused_ops: got %h %h want 1006 11", bus.ex_op_a, bus.ex_op_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b0, 8'h33);
        tick();
        bus.ex_ready = 1'b0;
        drive(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd11, 1'b0, 8'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.id_ready); end
            tick();
            checks++; if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 64'h11 || bus.ex_ctrl !== 8'h33 || bus.ex_rd !== 5'd10) begin
                errors++; $display("FAIL bp_hold[%0d]: got %b %h %h %0d want 1 11 33 10", i, bus.ex_valid, bus.ex_op_a, bus.ex_ctrl, bus.ex_rd);
            end
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.id_ready); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 64'h22 || bus.ex_op_b !== 64'h11 || bus.ex_ctrl !== 8'h44) begin
            errors++; $display("FAIL b2b_bundle: got %b %h %h %h want 1 22 11 44", bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_ctrl);
        end
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 8'h55);
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 8'h55) begin errors++; $display("FAIL throughput: got %b %h want 1 55", bus.ex_valid, bus.ex_ctrl); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b want 0", bus.ex_valid); end
    endtask

    task automatic test_reset_mid();
        bus.ex_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 8'h66);
        tick();
        bus.id_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_ctrl !== 8'd0) begin
            errors++; $display("FAIL mid_reset: got %b %0d %h want 0 0 0", bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
        end
        bus.ex_ready = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 8'h77);
        #1;
        checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_sb: got %b want 1", bus.id_ready); end
        tick();
        bus.id_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 64'h1009 || bus.ex_op_b !== 64'h1006) begin
            errors++; $display("FAIL mid_reset_issue: got %b %h %h want 1 1009 1006", bus.ex_valid, bus.ex_op_a, bus.ex_op_b);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_bypass();
        test_waw();
        test_unused_source();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
